imm_gen_pipe: RTL and testbench

Parametrised, registered successor to the single-cycle immediate extender. Decodes every RV32I/RV64I immediate format (I, S, B, U, J) from a raw instruction word and sign-extends it to XLEN. Sits between fetch/decode and execute in the pipelined core. Uses a valid/ready handshake with a 2-entry skid buffer, so decode never sees a combinational ready path from execute.

---
 rtl/imm_gen_pipe.sv | 86 ++++++++
 tb/tb_imm_gen_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate extender with valid/ready skid buffer; IMM_CSR_ZIMM_EN adds Z format
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inp,
    input  logic [2:0]       immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    logic [31:0]      imm32;
    logic [XLEN-1:0]  d_imm;
    logic             d_ill;
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_ill;
    logic             push;
    logic             pop;
    logic             unused;
    assign unused   = &{1'b0, inp[6:0]};
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign in_ready = !skid_valid && !rst;
    // decode the selected format into a 32-bit immediate, then sign-extend to XLEN
    always_comb begin
        d_ill = 1'b0;
        case (immsrc)
            3'd0:    imm32 = {{20{inp[31]}}, inp[31:20]};
            3'd1:    imm32 = {{20{inp[31]}}, inp[31:25], inp[11:7]};
            3'd2:    imm32 = {{19{inp[31]}}, inp[31], inp[7], inp[30:25], inp[11:8], 1'b0};
            3'd3:    imm32 = {inp[31:12], 12'h000};
            3'd4:    imm32 = {{11{inp[31]}}, inp[31], inp[19:12], inp[20], inp[30:21], 1'b0};
`ifdef IMM_CSR_ZIMM_EN
            3'd5:    imm32 = {27'd0, inp[19:15]};
`endif
            default: begin
                imm32 = 32'h0;
                d_ill = 1'b1;
            end
        endcase
        d_imm = XLEN'($signed(imm32));
    end
    // main drives the outputs; skid refills main on pop, new entries take main when it frees, else park in skid
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out        <= '0;
            out_tag    <= '0;
            illegal    <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
            skid_ill   <= 1'b0;
        end else if (skid_valid && pop) begin
            out_valid  <= 1'b1;
            out        <= skid_imm;
            out_tag    <= skid_tag;
            illegal    <= skid_ill;
            skid_valid <= 1'b0;
        end else if (!out_valid || pop) begin
            out_valid <= push;
            if (push) begin
                out     <= d_imm;
                out_tag <= in_tag;
                illegal <= d_ill;
            end
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_imm   <= d_imm;
            skid_tag   <= in_tag;
            skid_ill   <= d_ill;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;
    typedef struct packed {
        logic [31:0] i;
        logic [2:0]  s;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        ill;
    } vec_t;
`ifdef IMM_CSR_ZIMM_EN
    localparam logic [31:0] Z32 = 32'h0000_001F;
    localparam logic        ZIL = 1'b0;
`else
    localparam logic [31:0] Z32 = 32'h0;
    localparam logic        ZIL = 1'b1;
`endif
    localparam vec_t VEC [11] = '{
        '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0},
        '{32'hFE20AE23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0},
        '{32'hFE000CE3, 3'd2, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 1'b0},
        '{32'h123450B7, 3'd3, 32'h12345000, 64'h00000000_12345000, 1'b0},
        '{32'h0010006F, 3'd4, 32'h00000800, 64'h00000000_00000800, 1'b0},
        '{32'h800000B7, 3'd3, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0},
        '{32'h7FF00093, 3'd0, 32'h000007FF, 64'h00000000_000007FF, 1'b0},
        '{32'h80000013, 3'd0, 32'hFFFFF800, 64'hFFFFFFFF_FFFFF800, 1'b0},
        '{32'hFFFFFFFF, 3'd6, 32'h00000000, 64'h0, 1'b1},
        '{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0, 1'b1},
        '{32'h000F8073, 3'd5, Z32, {32'h0, Z32}, ZIL}
    };
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] inp = 32'h0;
    logic [2:0]  immsrc = 3'd0;
    logic [4:0]  in_tag = 5'd0;
    logic        ir32, ir64, ov32, ov64, il32, il64;
    logic [31:0] o32;
    logic [63:0] o64;
    logic [4:0]  ot32, ot64;
    int          checks = 0;
    int          failures = 0;
    always #5 clk = ~clk;
    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .inp(inp), .immsrc(immsrc),
        .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready), .out(o32), .out_tag(ot32), .illegal(il32)
    );
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64), .inp(inp), .immsrc(immsrc),
        .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready), .out(o64), .out_tag(ot64), .illegal(il64)
    );
    task automatic xfer(input logic [31:0] i, input logic [2:0] s, input logic [4:0] t);
        in_valid = 1'b1;
        inp      = i;
        immsrc   = s;
        in_tag   = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ir32, ir64, ov32, ov64, il32, il64, ot32, ot64, o32, o64} !== 112'h0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b%b v=%b%b out=%h/%h tag=%0d exp all zero", ir32, ir64, ov32, ov64, o32, o64, ot32);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ir32, ir64, ov32} !== 3'b110) begin
            failures++;
            $display("FAIL reset_release got rdy=%b%b v=%b exp rdy=11 v=0", ir32, ir64, ov32);
        end
    endtask
    task automatic test_formats;
        out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            xfer(VEC[k].i, VEC[k].s, 5'(k));
            checks++;
            if ({ov32, ov64, il32, il64, ot32, ot64, o32, o64} !==
                {2'b11, {2{VEC[k].ill}}, 5'(k), 5'(k), VEC[k].e32, VEC[k].e64}) begin
                failures++;
                $display("FAIL fmt[%0d] got v=%b%b ill=%b%b tag=%0d/%0d out=%h/%h exp ill=%b tag=%0d out=%h/%h",
                         k, ov32, ov64, il32, il64, ot32, ot64, o32, o64, VEC[k].ill, k, VEC[k].e32, VEC[k].e64);
            end
        end
    endtask
    task automatic test_latency;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ov32, ov64} !== 2'b00) begin
            failures++;
            $display("FAIL drain got v=%b%b exp 00", ov32, ov64);
        end
        xfer(32'hFFF00093, 3'd0, 5'd17);
        checks++;
        if ({ov32, ot32, o32} !== {1'b1, 5'd17, 32'hFFFFFFFF}) begin
            failures++;
            $display("FAIL latency got v=%b tag=%0d out=%h exp v=1 tag=17 out=ffffffff", ov32, ot32, o32);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ov32 !== 1'b0) begin
            failures++;
            $display("FAIL single_pop got v=%b exp 0", ov32);
        end
    endtask
    task automatic test_backpressure;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        immsrc    = 3'd0;
        inp       = 32'h00100093;
        in_tag    = 5'd1;
        @(posedge clk);
        #1;
        inp    = 32'h00200093;
        in_tag = 5'd2;
        checks++;
        if ({ov32, ot32, ir32, ir64} !== {1'b1, 5'd1, 2'b11}) begin
            failures++;
            $display("FAIL bp_first got v=%b tag=%0d rdy=%b%b exp v=1 tag=1 rdy=11", ov32, ot32, ir32, ir64);
        end
        @(posedge clk);
        #1;
        inp    = 32'h00300093;
        in_tag = 5'd3;
        checks++;
        if ({ir32, ir64, ot32, o32} !== {2'b00, 5'd1, 32'd1}) begin
            failures++;
            $display("FAIL bp_full got rdy=%b%b tag=%0d out=%h exp rdy=00 tag=1 out=1", ir32, ir64, ot32, o32);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({ov32, ir32, ot32, ot64, o32, o64} !== {2'b10, 5'd1, 5'd1, 32'd1, 64'd1}) begin
                failures++;
                $display("FAIL bp_stall got v=%b rdy=%b tag=%0d/%0d out=%h/%h exp v=1 rdy=0 tag=1 out=1", ov32, ir32, ot32, ot64, o32, o64);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ov32, ir32, ot32, o32} !== {2'b11, 5'd2, 32'd2}) begin
            failures++;
            $display("FAIL bp_pop1 got v=%b rdy=%b tag=%0d out=%h exp v=1 rdy=1 tag=2 out=2", ov32, ir32, ot32, o32);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if ({ov32, ot32, ot64, o32} !== {1'b1, 5'd3, 5'd3, 32'd3}) begin
            failures++;
            $display("FAIL bp_pop2 got v=%b tag=%0d/%0d out=%h exp v=1 tag=3 out=3", ov32, ot32, ot64, o32);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({ov32, ov64} !== 2'b00) begin
            failures++;
            $display("FAIL bp_drain got v=%b%b exp 00", ov32, ov64);
        end
    endtask
    task automatic test_reset_full;
        out_ready = 1'b0;
        xfer(32'h00700093, 3'd0, 5'd7);
        xfer(32'h00800093, 3'd6, 5'd8);
        checks++;
        if ({ov32, ir32} !== 2'b10) begin
            failures++;
            $display("FAIL rf_fill got v=%b rdy=%b exp v=1 rdy=0", ov32, ir32);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ir32, ir64, ov32, ov64, il32, il64, ot32, ot64, o32, o64} !== 112'h0) begin
            failures++;
            $display("FAIL rf_reset got rdy=%b%b v=%b%b out=%h/%h tag=%0d exp all zero", ir32, ir64, ov32, ov64, o32, o64, ot32);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ir32, ir64, ov32} !== 3'b110) begin
            failures++;
            $display("FAIL rf_release got rdy=%b%b v=%b exp rdy=11 v=0", ir32, ir64, ov32);
        end
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({ov32, ov64} !== 2'b00) begin
                failures++;
                $display("FAIL rf_stale got v=%b%b tag=%0d exp v=00", ov32, ov64, ot32);
            end
        end
        xfer(32'h0010006F, 3'd4, 5'd9);
        checks++;
        if ({ov32, ot32, il32, o32} !== {1'b1, 5'd9, 1'b0, 32'h800}) begin
            failures++;
            $display("FAIL rf_fresh got v=%b tag=%0d ill=%b out=%h exp v=1 tag=9 ill=0 out=800", ov32, ot32, il32, o32);
        end
    endtask
    initial begin
        test_reset;
        test_formats;
        test_latency;
        test_backpressure;
        test_reset_full;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
